// File: rtl/tick_scheduler_if.sv
// Configuration and tick bus of the tick scheduler.
// The master writes channel configuration; the slave returns the tick, busy and base_tick strobes.
interface tick_scheduler_if #(
   parameter int CNT_W = 16
);
   logic             cfg_we;
   logic [1:0]       cfg_ch;
   logic [1:0]       cfg_mode;
   logic [CNT_W-1:0] cfg_period;
   logic             base_tick;
   logic [3:0]       tick;
   logic [3:0]       busy;

   modport master (
      output cfg_we, cfg_ch, cfg_mode, cfg_period,
      input  base_tick, tick, busy
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_mode, cfg_period,
      output base_tick, tick, busy
   );
endinterface

// File: rtl/tick_scheduler.sv
// Four-channel tick scheduler: a free-running prescaler produces base ticks, and each channel
// divides them down into periodic or one-shot single-cycle enable pulses.
module tick_scheduler #(
   parameter int PRESCALE = 50000,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   tick_scheduler_if.slave  bus
);
   localparam int PC_W = $clog2(PRESCALE);

   typedef enum logic [1:0] {
      MODE_OFF      = 2'b00,
      MODE_PERIODIC = 2'b01,
      MODE_ONESHOT  = 2'b10
   } mode_t;

   logic [PC_W-1:0] pc_reg;
   logic [PC_W-1:0] pc_next;
   logic            base_tick_w;

   assign base_tick_w   = (pc_reg == PC_W'(PRESCALE - 1));
   assign bus.base_tick = base_tick_w;

   always_comb begin
      pc_next = pc_reg + PC_W'(1);
      if (base_tick_w) begin
         pc_next = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_reg <= '0;
      end else begin
         pc_reg <= pc_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : gen_ch
         mode_t            mode_reg;
         mode_t            mode_next;
         logic [CNT_W-1:0] period_reg;
         logic [CNT_W-1:0] period_next;
         logic [CNT_W-1:0] cnt_reg;
         logic [CNT_W-1:0] cnt_next;
         logic             tick_reg;
         logic             tick_next;
         logic             sel_w;
         logic             armed_w;

         assign sel_w   = bus.cfg_we && (bus.cfg_ch == 2'(gi));
         assign armed_w = (mode_reg == MODE_PERIODIC) || (mode_reg == MODE_ONESHOT);

         // A write to this channel wins over a coincident base tick: no tick, counter reloaded.
         always_comb begin
            mode_next   = mode_reg;
            period_next = period_reg;
            cnt_next    = cnt_reg;
            tick_next   = 1'b0;
            if (sel_w) begin
               period_next = bus.cfg_period;
               cnt_next    = bus.cfg_period;
               if ((bus.cfg_period == '0) || (bus.cfg_mode == 2'b11)) begin
                  mode_next = MODE_OFF;
               end else begin
                  mode_next = mode_t'(bus.cfg_mode);
               end
            end else if (base_tick_w && armed_w) begin
               if (cnt_reg > CNT_W'(1)) begin
                  cnt_next = cnt_reg - CNT_W'(1);
               end else if (cnt_reg == CNT_W'(1)) begin
                  tick_next = 1'b1;
                  if (mode_reg == MODE_PERIODIC) begin
                     cnt_next = period_reg;
                  end else begin
                     mode_next = MODE_OFF;
                  end
               end
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               mode_reg   <= MODE_OFF;
               period_reg <= '0;
               cnt_reg    <= '0;
               tick_reg   <= 1'b0;
            end else begin
               mode_reg   <= mode_next;
               period_reg <= period_next;
               cnt_reg    <= cnt_next;
               tick_reg   <= tick_next;
            end
         end

         assign bus.tick[gi] = tick_reg;
         assign bus.busy[gi] = armed_w;
      end
   endgenerate
endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with PRESCALE = 4; expected tick/busy timing is hand-derived
// from the cycle count since reset release.
module tb_tick_scheduler;
   localparam int PRESCALE = 4;
   localparam int CNT_W    = 16;

   logic clk;
   logic rst_n;
   int   vectors;
   int   errors;

   tick_scheduler_if #(.CNT_W(CNT_W)) bus ();

   tick_scheduler #(
      .PRESCALE (PRESCALE),
      .CNT_W    (CNT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_cfg(input logic [1:0] ch, input logic [1:0] mode, input logic [CNT_W-1:0] period);
      bus.cfg_we     = 1'b1;
      bus.cfg_ch     = ch;
      bus.cfg_mode   = mode;
      bus.cfg_period = period;
      step();
      bus.cfg_we     = 1'b0;
   endtask

   // Step n cycles; tick is expected from pattern A (mask ma, first fa, every pa cycles) OR pattern B.
   task automatic run_chk(input string tag, input int n, input logic [3:0] exp_busy,
                          input logic [3:0] ma, input int fa, input int pa,
                          input logic [3:0] mb, input int fb, input int pb);
      logic [3:0] exp_tick;
      for (int i = 1; i <= n; i++) begin
         step();
         exp_tick = 4'b0000;
         if (i >= fa && ((i - fa) % pa) == 0) exp_tick = exp_tick | ma;
         if (i >= fb && ((i - fb) % pb) == 0) exp_tick = exp_tick | mb;
         chk($sformatf("%s tick @%0d", tag, i), bus.tick, exp_tick);
         chk($sformatf("%s busy @%0d", tag, i), bus.busy, exp_busy);
      end
   endtask

   initial begin
      vectors        = 0;
      errors         = 0;
      rst_n          = 1'b0;
      bus.cfg_we     = 1'b0;
      bus.cfg_ch     = 2'd0;
      bus.cfg_mode   = 2'b00;
      bus.cfg_period = '0;

      repeat (3) step();
      chk("rst base_tick", {3'b000, bus.base_tick}, 4'b0000);
      chk("rst tick", bus.tick, 4'b0000);
      chk("rst busy", bus.busy, 4'b0000);

      // Release; cycle k counts rising edges since release.
      rst_n = 1'b1;
      chk("k0 base_tick", {3'b000, bus.base_tick}, 4'b0000);
      for (int k = 1; k <= 11; k++) begin
         step();
         chk($sformatf("rel base_tick @%0d", k), {3'b000, bus.base_tick}, {3'b000, (k % 4) == 3});
         chk($sformatf("rel tick @%0d", k), bus.tick, 4'b0000);
         chk($sformatf("rel busy @%0d", k), bus.busy, 4'b0000);
      end

      // k=12: ch0 periodic, period 3 -> ticks at k=24,36,48,60
      write_cfg(2'd0, 2'b01, 16'd3);
      chk("per busy", bus.busy, 4'b0001);
      run_chk("per", 48, 4'b0001, 4'b0001, 12, 12, 4'b0000, 1, 1);

      // Advance to k=71, the base tick where ch0 cnt == 1, then rewrite ch0 on that edge.
      run_chk("pre", 11, 4'b0001, 4'b0000, 1, 1, 4'b0000, 1, 1);
      chk("pre base_tick", {3'b000, bus.base_tick}, 4'b0001);
      write_cfg(2'd0, 2'b01, 16'd3);
      chk("rewr tick", bus.tick, 4'b0000);
      run_chk("rewr", 12, 4'b0001, 4'b0001, 12, 12, 4'b0000, 1, 1);

      // k=85: ch0 off; k=86: ch1 one-shot period 2 -> single tick at k=92
      write_cfg(2'd0, 2'b00, 16'd3);
      chk("off busy", bus.busy, 4'b0000);
      chk("off tick", bus.tick, 4'b0000);
      write_cfg(2'd1, 2'b10, 16'd2);
      chk("os busy", bus.busy, 4'b0010);
      run_chk("os_arm", 5, 4'b0010, 4'b0000, 1, 1, 4'b0000, 1, 1);
      run_chk("os_fire", 1, 4'b0000, 4'b0010, 1, 1, 4'b0000, 1, 1);
      run_chk("os_quiet", 100, 4'b0000, 4'b0000, 1, 1, 4'b0000, 1, 1);

      // ch2 with period 0, then with mode 11: both leave the channel off.
      write_cfg(2'd2, 2'b01, 16'd0);
      chk("p0 busy", bus.busy, 4'b0000);
      run_chk("p0", 40, 4'b0000, 4'b0000, 1, 1, 4'b0000, 1, 1);
      write_cfg(2'd2, 2'b11, 16'd5);
      chk("m11 busy", bus.busy, 4'b0000);
      run_chk("m11", 30, 4'b0000, 4'b0000, 1, 1, 4'b0000, 1, 1);

      // k=265: ch0 period 2; k=266: ch3 period 4 -> ch0 every 8 from k=272, ch3 every 16 from k=280
      write_cfg(2'd0, 2'b01, 16'd2);
      write_cfg(2'd3, 2'b01, 16'd4);
      chk("dual busy", bus.busy, 4'b1001);
      run_chk("dual", 46, 4'b1001, 4'b0001, 6, 8, 4'b1000, 14, 16);

      // Reset lands while the coincident tick is on the outputs.
      rst_n = 1'b0;
      #1;
      chk("midrst tick", bus.tick, 4'b0000);
      chk("midrst busy", bus.busy, 4'b0000);
      chk("midrst base_tick", {3'b000, bus.base_tick}, 4'b0000);
      repeat (2) step();
      rst_n = 1'b1;
      run_chk("post", 40, 4'b0000, 4'b0000, 1, 1, 4'b0000, 1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
